// File: rtl/chip_ctrl_pkg.sv
// chip_ctrl_pkg: opcodes, controller states and response bytes shared by the
// chip stepping controller and its testbench.
package chip_ctrl_pkg;

    typedef enum logic [7:0] {
        OP_SET_IN  = 8'h01,
        OP_STEP    = 8'h02,
        OP_RST_ON  = 8'h03,
        OP_RST_OFF = 8'h04,
        OP_READ    = 8'h05
    } opcode_e;

    typedef enum logic [2:0] {
        IDLE,
        ARG1,
        ARG2,
        CLK_HI,
        CLK_LO,
        SEND0,
        SEND1
    } state_e;

    localparam logic [7:0] ACK = 8'hA5;
    localparam logic [7:0] ERR = 8'hEE;

endpackage

// File: rtl/chip_clk_gen.sv
// chip_clk_gen: emits n pulses of a stepped clock, HALF_PERIOD cycles high then
// HALF_PERIOD cycles low each; done is high in the last low cycle of the last pulse.
module chip_clk_gen #(
    parameter int HALF_PERIOD = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic [8:0] n,
    output logic       chip_clock,
    output logic       done
);

    logic       run_q, run_d, hi_q, hi_d, last;
    logic [7:0] ph_q, ph_d;
    logic [8:0] cnt_q, cnt_d;

    always_comb begin
        last  = ph_q == 8'(HALF_PERIOD - 1);
        done  = run_q && !hi_q && last && cnt_q == 9'd1;
        run_d = start || (run_q && !done);
        hi_d  = start ? 1'b1 : (run_q && last) ? (!hi_q && !done) : hi_q;
        ph_d  = (start || !run_q || last) ? 8'd0 : ph_q + 8'd1;
        // the pulse count drops at the end of each low phase
        cnt_d = start ? n : (run_q && last && !hi_q) ? cnt_q - 9'd1 : cnt_q;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            run_q <= 1'b0;
            hi_q  <= 1'b0;
            ph_q  <= 8'd0;
            cnt_q <= 9'd0;
        end else begin
            run_q <= run_d;
            hi_q  <= hi_d;
            ph_q  <= ph_d;
            cnt_q <= cnt_d;
        end
    end

    assign chip_clock = hi_q;

endmodule

// File: rtl/chip_step_ctrl.sv
// chip_step_ctrl: byte-command controller between the UART harness and my_chip;
// sets chip inputs, steps the chip clock, drives chip reset and reads chip outputs.
module chip_step_ctrl #(
    parameter int HALF_PERIOD = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic [11:0] chip_inputs,
    input  logic [11:0] chip_outputs,
    output logic        chip_clock,
    output logic        chip_reset,
    output logic        busy
);

    import chip_ctrl_pkg::*;

    state_e      state_q, state_d;
    logic        en_q, set_q, set_d, rst_q, rst_d, start, done, rx_fire, tx_fire;
    logic [3:0]  arg_q, arg_d;
    logic [11:0] inputs_q, inputs_d, snap_q, snap_d;
    logic [7:0]  tx_data_q, tx_data_d;

    chip_clk_gen #(.HALF_PERIOD(HALF_PERIOD)) u_clk_gen (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .n          ({rx_data == 8'd0, rx_data}),
        .chip_clock (chip_clock),
        .done       (done)
    );

    // en_q keeps rx_ready low while reset is held and raises it one cycle after release
    assign rx_ready    = en_q && (state_q == IDLE || state_q == ARG1 || state_q == ARG2);
    assign tx_valid    = state_q == SEND0 || state_q == SEND1;
    assign busy        = state_q != IDLE;
    assign rx_fire     = rx_valid && rx_ready;
    assign tx_fire     = tx_valid && tx_ready;
    assign tx_data     = tx_data_q;
    assign chip_inputs = inputs_q;
    assign chip_reset  = rst_q;

    always_comb begin
        state_d   = state_q;
        set_d     = set_q;
        arg_d     = arg_q;
        inputs_d  = inputs_q;
        rst_d     = rst_q;
        snap_d    = snap_q;
        tx_data_d = tx_data_q;
        start     = 1'b0;
        case (state_q)
            IDLE: if (rx_fire) begin
                set_d = rx_data == OP_SET_IN;
                case (rx_data)
                    OP_SET_IN, OP_STEP: state_d = ARG1;
                    OP_RST_ON, OP_RST_OFF: begin
                        rst_d     = rx_data == OP_RST_ON;
                        tx_data_d = ACK;
                        state_d   = SEND1;
                    end
                    OP_READ: begin
                        snap_d    = chip_outputs;
                        tx_data_d = {4'h0, chip_outputs[11:8]};
                        state_d   = SEND0;
                    end
                    default: begin
                        tx_data_d = ERR;
                        state_d   = SEND1;
                    end
                endcase
            end
            ARG1: if (rx_fire) begin
                arg_d   = rx_data[3:0];
                start   = !set_q;
                state_d = set_q ? ARG2 : CLK_HI;
            end
            ARG2: if (rx_fire) begin
                inputs_d  = {arg_q, rx_data};
                tx_data_d = ACK;
                state_d   = SEND1;
            end
            CLK_HI: state_d = chip_clock ? CLK_HI : CLK_LO;
            CLK_LO: begin
                tx_data_d = done ? ACK : tx_data_q;
                state_d   = done ? SEND1 : chip_clock ? CLK_HI : CLK_LO;
            end
            SEND0: if (tx_fire) begin
                tx_data_d = snap_q[7:0];
                state_d   = SEND1;
            end
            SEND1: state_d = tx_fire ? IDLE : SEND1;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q   <= IDLE;
            en_q      <= 1'b0;
            set_q     <= 1'b0;
            arg_q     <= 4'h0;
            inputs_q  <= 12'h000;
            rst_q     <= 1'b1;
            snap_q    <= 12'h000;
            tx_data_q <= 8'h00;
        end else begin
            state_q   <= state_d;
            en_q      <= 1'b1;
            set_q     <= set_d;
            arg_q     <= arg_d;
            inputs_q  <= inputs_d;
            rst_q     <= rst_d;
            snap_q    <= snap_d;
            tx_data_q <= tx_data_d;
        end
    end

endmodule

// File: tb/tb_chip_step_ctrl.sv
// tb_chip_step_ctrl: directed command sequences against chip_step_ctrl with
// hand-computed expectations, sampled on the falling clock edge.
module tb_chip_step_ctrl;

    localparam int HP = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic        rx_ready;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b0;
    logic [11:0] chip_inputs;
    logic [11:0] chip_outputs = 12'h000;
    logic        chip_clock;
    logic        chip_reset;
    logic        busy;
    int          checks = 0;
    int          errors = 0;

    chip_step_ctrl #(.HALF_PERIOD(HP)) dut (
        .clock        (clock),
        .reset        (reset),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_ready     (rx_ready),
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .chip_inputs  (chip_inputs),
        .chip_outputs (chip_outputs),
        .chip_clock   (chip_clock),
        .chip_reset   (chip_reset),
        .busy         (busy)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        int k = 0;
        rx_data  = b;
        rx_valid = 1'b1;
        while (!rx_ready && k < 100) begin
            @(negedge clock);
            k++;
        end
        chk("rx_accept", 32'(rx_ready), 32'd1);
        @(negedge clock);
        rx_valid = 1'b0;
    endtask

    task automatic recv(input string tag, input logic [7:0] exp);
        int k = 0;
        tx_ready = 1'b1;
        while (!tx_valid && k < 100) begin
            @(negedge clock);
            k++;
        end
        chk({tag, "_valid"}, 32'(tx_valid), 32'd1);
        chk(tag, 32'(tx_data), 32'(exp));
        @(negedge clock);
        tx_ready = 1'b0;
    endtask

    task automatic pulses(input string tag, input int n);
        int hi = 0, lo = 0, cnt = 0, bad = 0, idle = 0, k = 0;
        logic prev = 1'b0;
        while (!tx_valid && k < 5000) begin
            if (chip_clock) begin
                if (!prev) begin
                    cnt++;
                    if (lo != 0 && lo != HP) bad++;
                    lo = 0;
                end
                hi++;
            end else begin
                if (prev) begin
                    if (hi != HP) bad++;
                    hi = 0;
                end
                lo++;
            end
            if (!busy) idle++;
            prev = chip_clock;
            k++;
            @(negedge clock);
        end
        chk({tag, "_count"}, 32'(cnt), 32'(n));
        chk({tag, "_phase"}, 32'(bad), 32'd0);
        chk({tag, "_last_lo"}, 32'(lo), 32'(HP));
        chk({tag, "_busy"}, 32'(idle), 32'd0);
    endtask

    initial begin
        int k;
        int seen;
        repeat (3) @(negedge clock);
        chk("rst_inputs", 32'(chip_inputs), 32'h000);
        chk("rst_chip_clock", 32'(chip_clock), 32'd0);
        chk("rst_chip_reset", 32'(chip_reset), 32'd1);
        chk("rst_tx_valid", 32'(tx_valid), 32'd0);
        chk("rst_tx_data", 32'(tx_data), 32'h00);
        chk("rst_rx_ready", 32'(rx_ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        reset = 1'b1;
        @(negedge clock);
        chk("release_rx_ready", 32'(rx_ready), 32'd1);

        send(8'h01);
        chk("arg1_busy", 32'(busy), 32'd1);
        send(8'h0A);
        chk("set_in_pending", 32'(chip_inputs), 32'h000);
        send(8'hBC);
        chk("set_in_value", 32'(chip_inputs), 32'hABC);
        recv("set_in_ack", 8'hA5);

        send(8'h02);
        send(8'h03);
        pulses("step3", 3);
        chk("step3_inputs", 32'(chip_inputs), 32'hABC);
        recv("step3_ack", 8'hA5);

        send(8'h02);
        send(8'h00);
        pulses("step256", 256);
        recv("step256_ack", 8'hA5);

        chip_outputs = 12'h5C3;
        send(8'h05);
        chip_outputs = 12'hFFF;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            if (!tx_valid || tx_data != 8'h05) seen++;
            @(negedge clock);
        end
        chk("read_hold", 32'(seen), 32'd0);
        recv("read_hi", 8'h05);
        recv("read_lo", 8'hC3);
        chk("read_idle", 32'(busy), 32'd0);

        send(8'h7F);
        recv("illegal_err", 8'hEE);
        send(8'h04);
        chk("rst_off_first", 32'(chip_reset), 32'd0);
        recv("rst_off_first_ack", 8'hA5);
        send(8'h03);
        chk("rst_on", 32'(chip_reset), 32'd1);
        recv("rst_on_ack", 8'hA5);
        send(8'h04);
        chk("rst_off", 32'(chip_reset), 32'd0);
        recv("rst_off_ack", 8'hA5);

        send(8'h02);
        send(8'h05);
        seen = 1;
        k = 0;
        while (seen < 2 && k < 200) begin
            logic prev;
            prev = chip_clock;
            @(negedge clock);
            if (chip_clock && !prev) seen++;
            k++;
        end
        chk("abort_reach_pulse2", 32'(seen), 32'd2);
        tx_ready = 1'b1;
        reset = 1'b0;
        @(negedge clock);
        chk("abort_chip_clock", 32'(chip_clock), 32'd0);
        chk("abort_chip_reset", 32'(chip_reset), 32'd1);
        chk("abort_tx_valid", 32'(tx_valid), 32'd0);
        reset = 1'b1;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (tx_valid || busy || chip_clock) seen++;
        end
        chk("abort_quiet", 32'(seen), 32'd0);
        chk("abort_rx_ready", 32'(rx_ready), 32'd1);
        tx_ready = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
